// File: rtl/gate_sweep_ctrl.sv
// Clocked sweep of a 2-input gate through {x,y} = 00,01,10,11.
// Each combination settles, then is sampled and compared against EXPECT.
module gate_sweep_ctrl #(
  parameter logic [3:0]  EXPECT = 4'b1001,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       s_in,
  output logic       x,
  output logic       y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] result,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  // Counter counts down to zero, so SETTLE cycles need a load of SETTLE-1.
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       x_q, x_d, y_q, y_d;
  logic       busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0] result_q, result_d, fail_q, fail_d;

  assign x         = x_q;
  assign y         = y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign result    = result_q;
  assign fail_mask = fail_q;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    result_d = result_q;
    fail_d   = fail_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (start) begin
          state_d  = S_SETTLE;
          busy_d   = 1'b1;
          idx_d    = 2'd0;
          x_d      = 1'b0;
          y_d      = 1'b0;
          cnt_d    = SETTLE_LD;
          pass_d   = 1'b0;
          result_d = 4'd0;
          fail_d   = 4'd0;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) state_d = S_SAMPLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_SAMPLE: begin
        result_d[idx_q] = s_in;
        fail_d[idx_q]   = s_in ^ EXPECT[idx_q];
        if (idx_q != 2'd3) begin
          idx_d   = idx_q + 2'd1;
          x_d     = idx_d[1];
          y_d     = idx_d[0];
          cnt_d   = SETTLE_LD;
          state_d = S_SETTLE;
        end else begin
          // pass reflects the mask including the sample just taken
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_d == 4'd0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      cnt_q    <= 4'd0;
      x_q      <= 1'b0;
      y_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      result_q <= 4'd0;
      fail_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      result_q <= result_d;
      fail_q   <= fail_d;
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: SETTLE=2 and SETTLE=1 instances, a per-cycle
// timeline model, table-driven truth-table sweeps and corner-case sequences.
module tb_gate_sweep_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, s0 = 1'b0, s1 = 1'b0;
  logic x0, y0, busy0, done0, pass0, x1, y1, busy1, done1, pass1;
  logic [3:0] res0, fm0, res1, fm1;

  gate_sweep_ctrl dut0 (
    .clk(clk), .reset(reset), .start(start0), .s_in(s0),
    .x(x0), .y(y0), .busy(busy0), .done(done0), .pass(pass0),
    .result(res0), .fail_mask(fm0)
  );
  gate_sweep_ctrl #(.EXPECT(4'b1001), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .s_in(s1),
    .x(x1), .y(y1), .busy(busy1), .done(done1), .pass(pass1),
    .result(res1), .fail_mask(fm1)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] EXP = 4'b1001;
  int vecs = 0, errs = 0;

  // Timeline model: k = 0 idle, 1..4*per busy cycle number, 4*per+1 done cycle.
  int         per[2] = '{3, 2};
  int         k[2] = '{0, 0};
  logic [3:0] m_res[2] = '{4'd0, 4'd0};
  logic [3:0] m_fm[2] = '{4'd0, 4'd0};
  logic       m_pass[2] = '{1'b0, 1'b0};
  logic [1:0] m_xy[2] = '{2'd0, 2'd0};
  logic [3:0] tbl[2] = '{4'b1001, 4'b1001};
  bit         glitch[2] = '{1'b0, 1'b0};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_step(input int d, input logic rst, input logic st, input logic si);
    int len;
    len = 4 * per[d];
    if (rst) begin
      k[d] = 0; m_res[d] = 4'd0; m_fm[d] = 4'd0; m_pass[d] = 1'b0; m_xy[d] = 2'd0;
    end else if ((k[d] == 0 || k[d] == len + 1) && st) begin
      k[d] = 1; m_res[d] = 4'd0; m_fm[d] = 4'd0; m_pass[d] = 1'b0; m_xy[d] = 2'd0;
    end else if (k[d] == len + 1) begin
      k[d] = 0;
    end else if (k[d] >= 1) begin
      if (k[d] % per[d] == 0) begin
        int i;
        i = k[d] / per[d] - 1;
        m_res[d][i] = si;
        m_fm[d][i]  = si ^ EXP[i];
      end
      k[d]++;
      if (k[d] <= len) m_xy[d] = 2'((k[d] - 1) / per[d]);
      else             m_pass[d] = (m_fm[d] == 4'd0);
    end
  endtask

  function automatic logic gate_out(input int d);
    int len;
    bit sample;
    len = 4 * per[d];
    sample = (k[d] >= 1) && (k[d] <= len) && (k[d] % per[d] == 0);
    if (!sample && glitch[d]) return logic'($urandom_range(0, 1));
    return tbl[d][m_xy[d]];
  endfunction

  always @(posedge clk) begin
    model_step(0, reset, start0, s0);
    model_step(1, reset, start1, s1);
  end

  // Every cycle: compare both instances against the model, then drive s_in.
  always @(negedge clk) begin
    check("model0", {19'd0, x0, y0, busy0, done0, pass0, res0, fm0},
          {19'd0, m_xy[0], (k[0] >= 1 && k[0] <= 12), (k[0] == 13), m_pass[0], m_res[0], m_fm[0]});
    check("model1", {19'd0, x1, y1, busy1, done1, pass1, res1, fm1},
          {19'd0, m_xy[1], (k[1] >= 1 && k[1] <= 8), (k[1] == 9), m_pass[1], m_res[1], m_fm[1]});
    s0 = gate_out(0);
    s1 = gate_out(1);
  end

  typedef struct {
    logic [3:0] gate;
    logic [3:0] exp_res;
    logic [3:0] exp_fm;
    logic       exp_pass;
  } vec_t;

  // Pulse start0 for one cycle, then return the done cycle number (1 = first busy cycle).
  task automatic sweep0(output int n);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 1;
    while (!done0 && n < 40) begin @(negedge clk); n++; end
  endtask

  initial begin
    vec_t vt[5];
    int n, dn, busy_len;
    int d_at[3];
    vt[0] = '{4'b1001, 4'b1001, 4'b0000, 1'b1};  // XNOR
    vt[1] = '{4'b1110, 4'b1110, 4'b0111, 1'b0};  // OR
    vt[2] = '{4'b1000, 4'b1000, 4'b0001, 1'b0};  // AND
    vt[3] = '{4'b0001, 4'b0001, 4'b1000, 1'b0};  // NOR
    vt[4] = '{4'b0110, 4'b0110, 4'b1111, 1'b0};  // XOR

    repeat (2) @(negedge clk);
    check("reset_state", {x0, y0, busy0, done0, pass0, res0, fm0}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      tbl[0] = vt[v].gate;
      glitch[0] = 1'b0;
      sweep0(n);
      check("done_cycle", n, 13);
      check("result", res0, vt[v].exp_res);
      check("fail_mask", fm0, vt[v].exp_fm);
      check("pass", pass0, vt[v].exp_pass);
      check("busy_in_done", busy0, 0);
      repeat (3) @(negedge clk);
      check("sticky", {res0, fm0, pass0}, {vt[v].exp_res, vt[v].exp_fm, vt[v].exp_pass});
    end

    // start held high: back-to-back sweeps every 13 cycles
    tbl[0] = 4'b1001;
    start0 = 1'b1;
    @(negedge clk);
    dn = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done0 && dn < 3) begin d_at[dn] = c; dn++; end
      if (c == 14) check("restart_busy_clear", {busy0, res0, pass0}, {1'b1, 4'd0, 1'b0});
      @(negedge clk);
    end
    start0 = 1'b0;
    check("held_done_count", dn, 3);
    check("held_done1", d_at[0], 13);
    check("held_done2", d_at[1], 26);
    check("held_done3", d_at[2], 39);
    n = 0;
    while (!done0 && n < 20) begin @(negedge clk); n++; end
    check("held_drain", done0, 1);
    @(negedge clk);

    // start pulsed during the third combination is ignored
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n = 1;
    while (n < 8) begin @(negedge clk); n++; end
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    n++;
    while (!done0 && n < 40) begin @(negedge clk); n++; end
    check("mid_start_done", n, 13);
    check("mid_start_res", {res0, fm0, pass0}, {4'b1001, 4'b0000, 1'b1});
    @(negedge clk);

    // reset while x,y = 10
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_xy", {x0, y0}, 2'b10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("post_reset", {x0, y0, busy0, done0, res0}, 8'd0);
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (done0) dn++;
      @(negedge clk);
    end
    check("no_done_after_reset", dn, 0);
    sweep0(n);
    check("after_reset_done", n, 13);
    check("after_reset_pass", {res0, pass0}, {4'b1001, 1'b1});
    @(negedge clk);

    // SETTLE=1 with glitches between sample edges
    tbl[1] = 4'b1001;
    glitch[1] = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n = 1;
    busy_len = 0;
    while (!done1 && n < 30) begin
      if (busy1) busy_len++;
      @(negedge clk);
      n++;
    end
    check("s1_busy_len", busy_len, 8);
    check("s1_done_cycle", n, 9);
    check("s1_pass", {res1, pass1}, {4'b1001, 1'b1});
    glitch[1] = 1'b0;
    @(negedge clk);

    // Random traffic against the timeline model
    for (int c = 0; c < 800; c++) begin
      if (c % 50 == 0) begin
        tbl[0] = 4'($urandom);
        tbl[1] = ($urandom_range(0, 1) == 1) ? 4'b1001 : 4'($urandom);
        glitch[0] = 1'($urandom);
        glitch[1] = 1'($urandom);
      end
      start0 = ($urandom_range(0, 5) == 0);
      start1 = ($urandom_range(0, 5) == 0);
      reset  = ($urandom_range(0, 120) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    start0 = 1'b0;
    start1 = 1'b0;
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Sequencer that exhaustively exercises a 2-input combinational gate unit, such as the NOR-built XNOR cell. It drives the unit's `x`/`y` inputs through all four combinations in order 00, 01, 10, 11. After a programmable settle time it samples the unit's output and compares each sample against an expected truth table. It sits between a start/status interface and one gate instance, replacing hand-written `#delay` stimulus with a clocked, self-checking sweep.

## Interface
Parameters:
- `EXPECT`, default 4'b1001: expected truth table; bit `i` is the expected output for `{x,y} = i` (default is XNOR).
- `SETTLE`, default 2: cycles the inputs are held before sampling; legal range 1..15.

Ports:
- `clk`  input  1  sole clock, rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  sweep request; sampled each rising edge.
- `s_in`  input  1  output of the gate under control.
- `x`  output  1  gate input A (registered).
- `y`  output  1  gate input B (registered).
- `busy`  output  1  high while a sweep is in progress.
- `done`  output  1  one-cycle pulse when a sweep completes.
- `pass`  output  1  high when the last sweep matched `EXPECT` completely; sticky.
- `result`  output  4  observed truth table; bit `i` is the sample for `{x,y} = i`; sticky.
- `fail_mask`  output  4  `result ^ EXPECT` per bit; sticky.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE. Internal registers: 2-bit index `idx` and a 4-bit settle counter.
- Reset values: state IDLE; `idx`=0, `x`=0, `y`=0, `busy`=0, `done`=0, `pass`=0, `result`=0, `fail_mask`=0.
- Reset has priority over every other input on the same edge.
- IDLE or DONE with `start`=1:
  - clear `result`, `fail_mask`, `pass`;
  - set `idx`=0 and `x`,`y`=0,0;
  - load the settle counter; go to SETTLE.
- IDLE with `start`=0: hold all outputs.
- SETTLE: occupies exactly `SETTLE` cycles with `x`,`y` held. `s_in` is ignored, so glitches are harmless. Then go to SAMPLE.
- SAMPLE: one cycle. At the edge ending this cycle:
  - `result[idx]` ← `s_in`;
  - `fail_mask[idx]` ← `s_in ^ EXPECT[idx]`.
  - If `idx`≠3: increment `idx`, drive `x`=`idx[1]`, `y`=`idx[0]` of the new index, go to SETTLE.
  - If `idx`=3: go to DONE.
- DONE: one cycle.
  - `done`=1, `busy`=0.
  - `pass` = (final `fail_mask` == 0), valid in this cycle and held afterwards.
  - Next state is IDLE, or SETTLE if `start`=1 (back-to-back sweep).
- In DONE and IDLE, `x`/`y` keep their last values (1,1).
- `start` in SETTLE or SAMPLE is ignored: no restart, no queuing, no change to completion time.
- `busy` is 1 in SETTLE and SAMPLE only. `busy` and `done` are never high together.

## Timing
- `start` sampled at edge E0 → `busy`=1 and `x`,`y`=00 in the cycle after E0.
- Each combination is presented for `SETTLE`+1 cycles. `s_in` is captured at the last edge of that window, so `s_in` must be stable within `SETTLE` cycles of the `x`/`y` change.
- `busy` lasts exactly 4·(`SETTLE`+1) cycles. With the default `SETTLE`=2 this is 12 cycles.
- `done` pulses in the cycle immediately after `busy` falls: cycle 13 after E0 for the default.
- `result`/`fail_mask` bits update progressively during the sweep. They are final, and `pass` is valid, in the `done` cycle.
- Reset mid-sweep: on the next cycle all outputs are at reset values and no `done` pulse occurs. A later `start` runs a full sweep from `idx`=0.

## Test plan
- XNOR cell on `s_in`, defaults, single-cycle `start`:
  - `x`/`y` run 00,01,10,11, each held 3 cycles;
  - `done` at cycle 13;
  - `result`=1001, `fail_mask`=0000, `pass`=1, held until the next `start`.
- `s_in`=x|y (wrong gate): `result`=1110, `fail_mask`=0111, `pass`=0 in the `done` cycle.
- `start` held high continuously:
  - `done` pulses every 13 cycles;
  - `busy` rises the cycle after each `done`;
  - `result` is cleared at each restart.
- `start` pulsed again during the third combination: ignored; `done` still at cycle 13; results unchanged from the single-start case.
- `reset` asserted while `x`,`y`=10:
  - next cycle `busy`=0, `x`=`y`=0, `result`=0, and no `done` pulse;
  - a subsequent `start` yields a complete correct sweep.
- `SETTLE`=1, XNOR cell: `busy` lasts 8 cycles, `done` at cycle 9, `pass`=1.
- `SETTLE`=1, `s_in` glitching 0/1 during settle cycles but correct on sample edges: `pass`=1.
